// File: rtl/acc_seq_responder.sv
// ACC offload responder: accepts one request at a time, executes ADD/SUB/MUL/MULDW
// (iterative radix-2 multiplier) and returns a tagged response from a held register.
module acc_seq_responder #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AccAddr   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic [IdWidth-1:0]   q_id_i,
  input  logic [31:0]          q_instr_data_i,
  input  logic [DataWidth-1:0] q_rs1_i,
  input  logic [DataWidth-1:0] q_rs2_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  output logic [DataWidth-1:0] p_data0_o,
  output logic [DataWidth-1:0] p_data1_o,
  output logic                 p_dual_writeback_o,
  output logic [4:0]           p_rd_o,
  output logic [IdWidth-1:0]   p_id_o,
  output logic                 p_error_o,
  output logic                 p_valid_o,
  input  logic                 p_ready_i
);

  localparam int unsigned CntWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntWidth-1:0]  CNT_LAST = CntWidth'(DataWidth - 1);
  localparam logic [AddrWidth-1:0] ACC_ADDR = AddrWidth'(AccAddr);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_MULDW = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_MULDW);
  endfunction

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULDW);
  endfunction

  function automatic logic [DataWidth-1:0] alu_result(input logic [2:0] op,
                                                     input logic [DataWidth-1:0] a,
                                                     input logic [DataWidth-1:0] b);
    logic [DataWidth-1:0] res;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      default: res = {DataWidth{1'b0}};
    endcase
    return res;
  endfunction

  state_e                     state_r, state_nxt_s;
  logic [CntWidth-1:0]        cnt_r;
  logic [DataWidth-1:0]       mcand_r;
  logic [2*DataWidth-1:0]     prod_r;
  logic                       dual_pend_r;
  logic [DataWidth-1:0]       data0_r, data1_r;
  logic                       dual_r, error_r, valid_r;
  logic [4:0]                 rd_r;
  logic [IdWidth-1:0]         id_r;

  logic [2:0]                 req_op_s;
  logic                       req_err_s;
  logic                       accept_s;
  logic                       mul_last_s;
  logic [DataWidth:0]         mul_sum_s;
  logic [2*DataWidth-1:0]     prod_nxt_s;
  logic                       unused_instr_s;

  assign req_op_s       = q_instr_data_i[14:12];
  assign req_err_s      = (q_addr_i != ACC_ADDR) || !op_legal(req_op_s);
  assign q_ready_o      = (state_r == ST_IDLE);
  assign accept_s       = q_valid_i && q_ready_o;
  assign mul_last_s     = (state_r == ST_EXEC) && (cnt_r == CNT_LAST);
  assign unused_instr_s = ^{q_instr_data_i[31:15], q_instr_data_i[6:0]};

  // One shift-add step: add the multiplicand to the upper half when the current
  // multiplier bit is set, then shift the whole product (with carry) right by one.
  always_comb begin
    mul_sum_s  = {1'b0, prod_r[2*DataWidth-1:DataWidth]};
    prod_nxt_s = prod_r;
    if (prod_r[0]) begin
      mul_sum_s = {1'b0, prod_r[2*DataWidth-1:DataWidth]} + {1'b0, mcand_r};
    end else begin
      mul_sum_s = {1'b0, prod_r[2*DataWidth-1:DataWidth]};
    end
    prod_nxt_s = {mul_sum_s, prod_r[DataWidth-1:1]};
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_err_s || !op_is_mul(req_op_s)) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_EXEC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (p_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture, multiplier iteration and the held response register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r       <= {CntWidth{1'b0}};
      mcand_r     <= {DataWidth{1'b0}};
      prod_r      <= {(2*DataWidth){1'b0}};
      dual_pend_r <= 1'b0;
      data0_r     <= {DataWidth{1'b0}};
      data1_r     <= {DataWidth{1'b0}};
      dual_r      <= 1'b0;
      error_r     <= 1'b0;
      valid_r     <= 1'b0;
      rd_r        <= 5'd0;
      id_r        <= {IdWidth{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            id_r  <= q_id_i;
            rd_r  <= q_instr_data_i[11:7];
            cnt_r <= {CntWidth{1'b0}};
            if (req_err_s) begin
              data0_r <= {DataWidth{1'b0}};
              data1_r <= {DataWidth{1'b0}};
              dual_r  <= 1'b0;
              error_r <= 1'b1;
              valid_r <= 1'b1;
            end else if (op_is_mul(req_op_s)) begin
              mcand_r     <= q_rs1_i;
              prod_r      <= {{DataWidth{1'b0}}, q_rs2_i};
              dual_pend_r <= (req_op_s == OP_MULDW);
              error_r     <= 1'b0;
            end else begin
              data0_r <= alu_result(req_op_s, q_rs1_i, q_rs2_i);
              data1_r <= {DataWidth{1'b0}};
              dual_r  <= 1'b0;
              error_r <= 1'b0;
              valid_r <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          prod_r <= prod_nxt_s;
          cnt_r  <= cnt_r + CntWidth'(1);
          if (mul_last_s) begin
            data0_r <= prod_nxt_s[DataWidth-1:0];
            data1_r <= dual_pend_r ? prod_nxt_s[2*DataWidth-1:DataWidth] : {DataWidth{1'b0}};
            dual_r  <= dual_pend_r;
            valid_r <= 1'b1;
          end
        end
        ST_RESP: begin
          if (p_ready_i) begin
            valid_r <= 1'b0;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign p_data0_o          = data0_r;
  assign p_data1_o          = data1_r;
  assign p_dual_writeback_o = dual_r;
  assign p_rd_o             = rd_r;
  assign p_id_o             = id_r;
  assign p_error_o          = error_r;
  assign p_valid_o          = valid_r;

endmodule

// File: tb/tb_acc_seq_responder.sv
// Directed and randomized checks of acc_seq_responder against an arithmetic reference model.
module tb_acc_seq_responder;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] q_addr;
  logic [IW-1:0] q_id;
  logic [31:0]   q_instr;
  logic [DW-1:0] q_rs1, q_rs2;
  logic          q_valid, q_ready;
  logic [DW-1:0] p_data0, p_data1;
  logic          p_dual, p_error, p_valid, p_ready;
  logic [4:0]    p_rd;
  logic [IW-1:0] p_id;

  int n_checks = 0;
  int n_pass   = 0;
  logic [IW-1:0] id_q[$];

  acc_seq_responder #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .AccAddr(0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .q_addr_i(q_addr), .q_id_i(q_id), .q_instr_data_i(q_instr),
    .q_rs1_i(q_rs1), .q_rs2_i(q_rs2), .q_valid_i(q_valid), .q_ready_o(q_ready),
    .p_data0_o(p_data0), .p_data1_o(p_data1), .p_dual_writeback_o(p_dual),
    .p_rd_o(p_rd), .p_id_o(p_id), .p_error_o(p_error),
    .p_valid_o(p_valid), .p_ready_i(p_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: results straight from the op definitions using 64-bit arithmetic.
  function automatic void model(input logic [AW-1:0] addr, input logic [2:0] op,
                                input logic [DW-1:0] a, input logic [DW-1:0] b,
                                output logic [DW-1:0] d0, output logic [DW-1:0] d1,
                                output logic dual, output logic err, output int lat);
    logic [63:0] prod;
    prod = {32'h0, a} * {32'h0, b};
    d0 = '0; d1 = '0; dual = 1'b0; err = 1'b0; lat = 1;
    if (addr != 0) err = 1'b1;
    else begin
      case (op)
        3'd0: d0 = a + b;
        3'd1: d0 = a - b;
        3'd2: begin d0 = prod[31:0]; lat = DW + 1; end
        3'd3: begin d0 = prod[31:0]; d1 = prod[63:32]; dual = 1'b1; lat = DW + 1; end
        default: err = 1'b1;
      endcase
    end
  endfunction

  // Issue one request from a negedge in IDLE, check latency, payload, stall stability, handshake.
  task automatic run_req(input string tag, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                         input logic [2:0] op, input logic [4:0] rd,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic early, input int stall);
    logic [31:0]   instr;
    logic [DW-1:0] e0, e1;
    logic          ed, ee;
    int            elat, lat;
    logic [127:0]  snap;
    instr = $urandom;
    instr[14:12] = op;
    instr[11:7]  = rd;
    model(addr, op, a, b, e0, e1, ed, ee, elat);
    chk({tag, ":idle_ready"}, q_ready, 1);
    q_addr = addr; q_id = id; q_instr = instr; q_rs1 = a; q_rs2 = b;
    q_valid = 1'b1; p_ready = early;
    id_q.push_back(id);
    @(negedge clk);
    q_valid = 1'b0; q_rs1 = $urandom; q_rs2 = $urandom; q_id = IW'($urandom);
    lat = 1;
    while (!p_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, lat, elat);
    chk({tag, ":data0"}, p_data0, e0);
    chk({tag, ":data1"}, p_data1, e1);
    chk({tag, ":dual"}, p_dual, ed);
    chk({tag, ":error"}, p_error, ee);
    chk({tag, ":id_order"}, p_id, id_q.pop_front());
    chk({tag, ":rd"}, p_rd, rd);
    chk({tag, ":busy"}, q_ready, 0);
    snap = {p_data0, p_data1, p_dual, p_error, p_id, p_rd};
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, ":stall_stable"}, {p_data0, p_data1, p_dual, p_error, p_id, p_rd}, snap);
        chk({tag, ":stall_valid"}, p_valid, 1);
        chk({tag, ":stall_busy"}, q_ready, 0);
      end
      p_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, ":post_valid"}, p_valid, 0);
    chk({tag, ":post_ready"}, q_ready, 1);
    p_ready = 1'b0;
  endtask

  initial begin
    int hits;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] a, b;
    rst_n = 1'b0; q_addr = '0; q_id = '0; q_instr = '0; q_rs1 = '0; q_rs2 = '0;
    q_valid = 1'b0; p_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:q_ready", q_ready, 1);
    chk("rst:p_valid", p_valid, 0);
    chk("rst:outputs", {p_data0, p_data1, p_dual, p_error, p_id, p_rd}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst:idle_after", {q_ready, p_valid}, 2'b10);

    run_req("add_wrap", 4'd0, 4'd3, 3'b000, 5'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    run_req("sub_wrap", 4'd0, 4'd1, 3'b001, 5'd7, 32'd1, 32'd2, 1'b1, 0);
    run_req("mul_low", 4'd0, 4'd2, 3'b010, 5'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1);
    run_req("muldw_max", 4'd0, 4'd4, 3'b011, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_req("muldw_zero", 4'd0, 4'd6, 3'b011, 5'd2, 32'h0, 32'hDEAD_BEEF, 1'b1, 0);
    run_req("illegal_op", 4'd0, 4'd9, 3'b111, 5'd17, 32'h55, 32'h66, 1'b0, 0);
    run_req("addr_miss", 4'd5, 4'd9, 3'b000, 5'd30, 32'h55, 32'h66, 1'b0, 0);
    run_req("stall10", 4'd0, 4'd11, 3'b000, 5'd12, 32'hCAFE_0000, 32'h0000_BABE, 1'b0, 10);

    // Reset at multiplier step 10 must drop the request.
    q_addr = '0; q_id = 4'd13; q_instr = 32'h0000_3000 | (32'd4 << 7);
    q_rs1 = 32'd77; q_rs2 = 32'd99; q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst:q_ready", q_ready, 1);
    chk("midrst:p_valid", p_valid, 0);
    chk("midrst:outputs", {p_data0, p_data1, p_dual, p_error, p_id, p_rd}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    p_ready = 1'b1;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (p_valid) hits++;
    end
    chk("midrst:no_response", hits, 0);
    chk("midrst:idle", q_ready, 1);
    p_ready = 1'b0;

    for (int n = 0; n < 1000; n++) begin
      int sel;
      sel  = $urandom_range(0, 9);
      addr = '0;
      op   = 3'($urandom_range(0, 3));
      if (sel == 8) op = 3'($urandom_range(4, 7));
      if (sel == 9) addr = AW'($urandom_range(1, 15));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
      run_req("rand", addr, IW'($urandom), op, 5'($urandom), a, b,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
